// File: rtl/alu_registrada.sv
// Registered ALU stage fed by the Mux_A/Mux_B operand selectors.
// Single-cycle ops write rC in one clock. MUL is an iterative LSB-first shift-add
// taking SIZE cycles and uses a start/busy/done handshake.
module alu_registrada #(
   parameter int unsigned SIZE = 8
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            wStart,
   input  logic [2:0]      wOp,
   input  logic [SIZE-1:0] wA,
   input  logic [SIZE-1:0] wB,
   output logic [SIZE-1:0] rC,
   output logic            rCarry,
   output logic            rZero,
   output logic            rBusy,
   output logic            rDone
);

   localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpOr   = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpShl  = 3'b101;
   localparam logic [2:0] OpMul  = 3'b110;
   localparam logic [2:0] OpPass = 3'b111;

   typedef enum logic [0:0] {StIdle, StMul} state_t;

   state_t              state;
   logic [2*SIZE-1:0]   acc;
   logic [2*SIZE-1:0]   mul_a;
   logic [SIZE-1:0]     mul_b;
   logic [CW-1:0]       cnt;

   logic [SIZE:0]       add_w;
   logic [SIZE:0]       sub_w;
   logic [SIZE-1:0]     op_res;
   logic                op_carry;
   logic [2*SIZE-1:0]   mul_sum;

   // Combinational result and carry for the single-cycle opcodes.
   always_comb begin
      add_w    = {1'b0, wA} + {1'b0, wB};
      sub_w    = {1'b0, wA} - {1'b0, wB};
      op_res   = '0;
      op_carry = 1'b0;
      case (wOp)
         OpAdd:  begin op_res = add_w[SIZE-1:0]; op_carry = add_w[SIZE]; end
         // Bit SIZE of the widened difference is the unsigned borrow.
         OpSub:  begin op_res = sub_w[SIZE-1:0]; op_carry = sub_w[SIZE]; end
         OpAnd:  op_res = wA & wB;
         OpOr:   op_res = wA | wB;
         OpXor:  op_res = wA ^ wB;
         OpShl:  begin op_res = {wA[SIZE-2:0], 1'b0}; op_carry = wA[SIZE-1]; end
         OpPass: op_res = wB;
         default: begin op_res = '0; op_carry = 1'b0; end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current B bit is set.
   always_comb begin
      mul_sum = acc + (mul_b[0] ? mul_a : '0);
   end

   // State machine with registered result, flags and handshake outputs.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state  <= StIdle;
         rC     <= '0;
         rCarry <= 1'b0;
         rZero  <= 1'b1;
         rBusy  <= 1'b0;
         rDone  <= 1'b0;
         acc    <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         cnt    <= '0;
      end else begin
         rDone <= 1'b0;
         case (state)
            StIdle: begin
               if (wStart) begin
                  if (wOp == OpMul) begin
                     // Operands are latched so later wA/wB changes cannot corrupt the product.
                     mul_a <= {{SIZE{1'b0}}, wA};
                     mul_b <= wB;
                     acc   <= '0;
                     cnt   <= '0;
                     rBusy <= 1'b1;
                     state <= StMul;
                  end else begin
                     rC     <= op_res;
                     rCarry <= op_carry;
                     rZero  <= (op_res == '0);
                     rDone  <= 1'b1;
                  end
               end
            end
            StMul: begin
               if (cnt == CW'(SIZE - 1)) begin
                  rC     <= mul_sum[SIZE-1:0];
                  rCarry <= |mul_sum[2*SIZE-1:SIZE];
                  rZero  <= (mul_sum[SIZE-1:0] == '0);
                  rDone  <= 1'b1;
                  rBusy  <= 1'b0;
                  acc    <= mul_sum;
                  state  <= StIdle;
               end else begin
                  acc   <= mul_sum;
                  mul_a <= {mul_a[2*SIZE-2:0], 1'b0};
                  mul_b <= {1'b0, mul_b[SIZE-1:1]};
                  cnt   <= cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
